// File: rtl/fft_pkg.sv
// Shared definitions for the streaming 4-point FFT: default widths and the
// per-frame mode word that travels down the pipeline with the data.
package fft_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic inverse;
    logic scale;
  } mode_t;

endpackage

// File: rtl/fft_bfly2.sv
// Radix-2 butterfly: a+b and a-b at IN_W+1 bits, optionally halved (floor).
module fft_bfly2 #(
  parameter int IN_W = 16
) (
  input  logic signed [IN_W-1:0] a,
  input  logic signed [IN_W-1:0] b,
  input  logic                   scale,
  output logic signed [IN_W:0]   sum,
  output logic signed [IN_W:0]   dif
);

  function automatic logic signed [IN_W:0] halve(input logic signed [IN_W:0] v,
                                                 input logic en);
    return en ? (v >>> 1) : v;
  endfunction

  logic signed [IN_W:0] sum_full;
  logic signed [IN_W:0] dif_full;

  assign sum_full = {a[IN_W-1], a} + {b[IN_W-1], b};
  assign dif_full = {a[IN_W-1], a} - {b[IN_W-1], b};

  assign sum = halve(sum_full, scale);
  assign dif = halve(dif_full, scale);

endmodule

// File: rtl/fft4_stream_pipe.sv
// Streaming 4-point radix-2 DIT FFT/IFFT, one frame per cycle, two register
// stages with valid/ready flow control on both sides and an output frame counter.
module fft4_stream_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inverse,
  input  logic                   in_scale,
  input  logic [4*WIDTH-1:0]     x_re,
  input  logic [4*WIDTH-1:0]     x_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_inverse,
  output logic [4*(WIDTH+2)-1:0] y_re,
  output logic [4*(WIDTH+2)-1:0] y_im,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int S1_W  = WIDTH + 1;
  localparam int OUT_W = WIDTH + 2;

  logic signed [WIDTH-1:0] xr [4];
  logic signed [WIDTH-1:0] xi [4];
  logic signed [S1_W-1:0]  s1r [4];
  logic signed [S1_W-1:0]  s1i [4];
  logic signed [S1_W-1:0]  ar_p1 [4];
  logic signed [S1_W-1:0]  ai_p1 [4];
  logic                    vld_p1;
  mode_t                   mode_p1;
  mode_t                   in_mode;

  logic signed [OUT_W-1:0] y0r, y2r, y0i, y2i;
  logic signed [OUT_W-1:0] ps, pd, qs, qd;
  logic signed [OUT_W-1:0] yr [4];
  logic signed [OUT_W-1:0] yi [4];

  logic s1_en;
  logic s2_en;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !vld_p1 || s2_en;
  assign in_ready = s1_en;
  assign in_mode  = mode_t'{inverse: in_inverse, scale: in_scale};

  for (genvar k = 0; k < 4; k++) begin : g_unpack
    assign xr[k] = x_re[k*WIDTH +: WIDTH];
    assign xi[k] = x_im[k*WIDTH +: WIDTH];
  end

  // ---- stage 1: even/odd 2-point butterflies on the raw input ----
  fft_bfly2 #(.IN_W(WIDTH)) u_s1_r02 (.a(xr[0]), .b(xr[2]), .scale(in_scale), .sum(s1r[0]), .dif(s1r[2]));
  fft_bfly2 #(.IN_W(WIDTH)) u_s1_r13 (.a(xr[1]), .b(xr[3]), .scale(in_scale), .sum(s1r[1]), .dif(s1r[3]));
  fft_bfly2 #(.IN_W(WIDTH)) u_s1_i02 (.a(xi[0]), .b(xi[2]), .scale(in_scale), .sum(s1i[0]), .dif(s1i[2]));
  fft_bfly2 #(.IN_W(WIDTH)) u_s1_i13 (.a(xi[1]), .b(xi[3]), .scale(in_scale), .sum(s1i[1]), .dif(s1i[3]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      mode_p1 <= '0;
      ar_p1   <= '{default: '0};
      ai_p1   <= '{default: '0};
    end else if (s1_en) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        mode_p1 <= in_mode;
        ar_p1   <= s1r;
        ai_p1   <= s1i;
      end
    end
  end

  // ---- stage 2: combine halves; the -j/+j twiddle is folded into operand pairing ----
  fft_bfly2 #(.IN_W(S1_W)) u_s2_r01 (.a(ar_p1[0]), .b(ar_p1[1]), .scale(mode_p1.scale), .sum(y0r), .dif(y2r));
  fft_bfly2 #(.IN_W(S1_W)) u_s2_i01 (.a(ai_p1[0]), .b(ai_p1[1]), .scale(mode_p1.scale), .sum(y0i), .dif(y2i));
  fft_bfly2 #(.IN_W(S1_W)) u_s2_rx  (.a(ar_p1[2]), .b(ai_p1[3]), .scale(mode_p1.scale), .sum(ps),  .dif(pd));
  fft_bfly2 #(.IN_W(S1_W)) u_s2_ix  (.a(ai_p1[2]), .b(ar_p1[3]), .scale(mode_p1.scale), .sum(qs),  .dif(qd));

  // Inverse simply exchanges bins 1 and 3 of the forward result.
  always_comb begin
    yr[0] = y0r;
    yi[0] = y0i;
    yr[2] = y2r;
    yi[2] = y2i;
    yr[1] = ps;
    yi[1] = qd;
    yr[3] = pd;
    yi[3] = qs;
    if (mode_p1.inverse) begin
      yr[1] = pd;
      yi[1] = qs;
      yr[3] = ps;
      yi[3] = qd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_inverse <= 1'b0;
      y_re        <= '0;
      y_im        <= '0;
    end else if (s2_en) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_inverse <= mode_p1.inverse;
        for (int k = 0; k < 4; k++) begin
          y_re[k*OUT_W +: OUT_W] <= yr[k];
          y_im[k*OUT_W +: OUT_W] <= yi[k];
        end
      end
    end
  end

  // ---- output handshake counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (out_valid && out_ready) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft4_stream_pipe.sv
// Self-checking bench for fft4_stream_pipe: directed vectors, backpressure,
// mid-flight reset and randomized traffic against a twiddle-based DFT model.
module tb_fft4_stream_pipe;

  localparam int W  = 16;
  localparam int OW = W + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_inverse;
  logic            in_scale;
  logic [4*W-1:0]  x_re;
  logic [4*W-1:0]  x_im;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_inverse;
  logic [4*OW-1:0] y_re;
  logic [4*OW-1:0] y_im;
  logic [15:0]     frame_cnt;

  int n_chk = 0;
  int n_err = 0;
  int rdy_mode = 0;  // 0: always ready, 1: stalled, 2: random

  typedef struct {
    logic [4*OW-1:0] re;
    logic [4*OW-1:0] im;
    logic            inv;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_cnt = '0;

  fft4_stream_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inverse(in_inverse), .in_scale(in_scale),
    .x_re(x_re), .x_im(x_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inverse(out_inverse),
    .y_re(y_re), .y_im(y_im),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // DFT of length 4 computed as two length-2 DFTs joined by the twiddle W = -j
  // (forward) or +j (inverse), with optional floor-halving after each half.
  function automatic exp_t model(input logic [4*W-1:0] xr_p, input logic [4*W-1:0] xi_p,
                                 input logic inv, input logic scl);
    exp_t r;
    int xr[4], xi[4], er[2], ei[2], orr[2], oi[2], tr, ti, yr[4], yi[4];
    for (int k = 0; k < 4; k++) begin
      xr[k] = signed'(xr_p[k*W +: W]);
      xi[k] = signed'(xi_p[k*W +: W]);
    end
    // even-index and odd-index 2-point DFTs
    er[0] = xr[0] + xr[2];  er[1] = xr[0] - xr[2];
    ei[0] = xi[0] + xi[2];  ei[1] = xi[0] - xi[2];
    orr[0] = xr[1] + xr[3]; orr[1] = xr[1] - xr[3];
    oi[0] = xi[1] + xi[3];  oi[1] = xi[1] - xi[3];
    if (scl) begin
      for (int k = 0; k < 2; k++) begin
        er[k] = er[k] >>> 1;  ei[k] = ei[k] >>> 1;
        orr[k] = orr[k] >>> 1; oi[k] = oi[k] >>> 1;
      end
    end
    // multiply odd bin 1 by the twiddle: (-j)(r+ji) = i - jr ; (+j)(r+ji) = -i + jr
    tr = inv ? -oi[1] : oi[1];
    ti = inv ? orr[1] : -orr[1];
    yr[0] = er[0] + orr[0]; yi[0] = ei[0] + oi[0];
    yr[2] = er[0] - orr[0]; yi[2] = ei[0] - oi[0];
    yr[1] = er[1] + tr;     yi[1] = ei[1] + ti;
    yr[3] = er[1] - tr;     yi[3] = ei[1] - ti;
    for (int k = 0; k < 4; k++) begin
      if (scl) begin
        yr[k] = yr[k] >>> 1;
        yi[k] = yi[k] >>> 1;
      end
      r.re[k*OW +: OW] = yr[k][OW-1:0];
      r.im[k*OW +: OW] = yi[k][OW-1:0];
    end
    r.inv = inv;
    return r;
  endfunction

  function automatic logic [4*W-1:0] packx(input int v0, input int v1, input int v2, input int v3);
    logic [4*W-1:0] r;
    r = {v3[W-1:0], v2[W-1:0], v1[W-1:0], v0[W-1:0]};
    return r;
  endfunction

  function automatic logic [4*OW-1:0] packy(input int v0, input int v1, input int v2, input int v3);
    logic [4*OW-1:0] r;
    r = {v3[OW-1:0], v2[OW-1:0], v1[OW-1:0], v0[OW-1:0]};
    return r;
  endfunction

  // Scoreboard: values at the falling edge are the ones the next rising edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_re", y_re, e.re);
          chk("sb_im", y_im, e.im);
          chk("sb_inv", out_inverse, e.inv);
          chk("sb_cnt", frame_cnt, exp_cnt);
          exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (in_valid && in_ready) q.push_back(model(x_re, x_im, in_inverse, in_scale));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic set_frame(input logic [4*W-1:0] xr, input logic [4*W-1:0] xi,
                           input logic inv, input logic scl);
    x_re = xr; x_im = xi; in_inverse = inv; in_scale = scl; in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    logic hs;
    hs = 1'b0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!hs) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!out_valid && q.size() == 0) return;
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic run_dir(input string tag, input logic [4*W-1:0] xr, input logic [4*W-1:0] xi,
                         input logic inv, input logic scl,
                         input logic [4*OW-1:0] er, input logic [4*OW-1:0] ei);
    int n;
    set_frame(xr, xi, inv, scl);
    wait_accept();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 8);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_re"}, y_re, er);
    chk({tag, "_im"}, y_im, ei);
    chk({tag, "_inv"}, out_inverse, inv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4*OW-1:0] held_re, held_im;
    logic [15:0]     base;
    rst_n = 1'b0; in_valid = 1'b0; in_inverse = 1'b0; in_scale = 1'b0;
    x_re = '0; x_im = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y_re", y_re, 0);
    chk("rst_y_im", y_im, 0);
    chk("rst_inv", out_inverse, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors
    run_dir("impulse", packx(1, 0, 0, 0), '0, 1'b0, 1'b0, packy(1, 1, 1, 1), '0);
    run_dir("ramp_fwd", packx(1, 2, 3, 4), '0, 1'b0, 1'b0, packy(10, -2, -2, -2), packy(0, 2, 0, -2));
    run_dir("ramp_inv", packx(1, 2, 3, 4), '0, 1'b1, 1'b0, packy(10, -2, -2, -2), packy(0, -2, 0, 2));
    run_dir("ramp_scl", packx(4, 8, 12, 16), '0, 1'b0, 1'b1, packy(10, -2, -2, -2), packy(0, 2, 0, -2));
    run_dir("full_neg", packx(-32768, -32768, -32768, -32768), '0, 1'b0, 1'b0,
            packy(-131072, 0, 0, 0), '0);
    wait_drain();

    // backpressure: two frames queued behind a stalled output, a third waits
    base = exp_cnt;
    rdy_mode = 1;
    @(posedge clk);
    #2;
    set_frame({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    wait_accept();
    set_frame({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    wait_accept();
    set_frame({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
    @(negedge clk);
    held_re = y_re;
    held_im = y_im;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_re", y_re, held_re);
      chk("bp_hold_im", y_im, held_im);
      @(posedge clk);
      @(negedge clk);
    end
    rdy_mode = 0;
    wait_accept();
    wait_drain();
    chk("bp_cnt", frame_cnt, base + 16'd3);

    // reset with a frame sitting in the first stage
    set_frame({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    wait_accept();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_y_re", y_re, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;

    // randomized traffic with random output stalls and input gaps
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      set_frame({$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_accept();
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    wait_drain();
    chk("final_queue_empty", q.size(), 0);
    chk("final_cnt", frame_cnt, exp_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
